fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the fetch PC for the single-issue RV32 core and sequences instruction fetch.
- Selects the next PC: sequential, branch/jump redirect, or trap vector.
- Issues one request at a time to instruction memory over a req/gnt/rvalid handshake.
- Hands the fetched instruction to decode over a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- TRAP_VEC, 32'h0000_0100, fetch target on trap_valid.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_gnt=0.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; arrives at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  instruction to decode.
- if_ready  in  1  decode accepts when if_valid=1.
- redirect_valid  in  1  branch/jump taken, 1-cycle pulse.
- redirect_pc  in  32  redirect target.
- trap_valid  in  1  trap/exception, 1-cycle pulse.
- pc_misaligned  out  1  misaligned-target pulse; only live with MISALIGN_TRAP_EN.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC, kill=0, pending=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), pc_misaligned=0.
- imem_addr is driven directly from the fetch_pc register.
- FSM:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1. On gnt -> WAIT.
  - WAIT: imem_req=0. On rvalid with kill=0: capture if_instr<=rdata, if_pc<=fetch_pc, go HOLD. On rvalid with kill=1: discard data, fetch_pc<=pending, kill<=0, go REQ.
  - HOLD: if_valid=1; if_pc/if_instr stable until accepted. On if_valid&&if_ready: fetch_pc<=fetch_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go REQ.
- Maximum one outstanding request.
- Steady-state throughput: 1 instruction per 3 cycles (REQ/WAIT/HOLD) with gnt, rvalid and ready each in 1 cycle.
- Next-target priority in a cycle: trap_valid (target TRAP_VEC) > redirect_valid (target redirect_pc).
- Redirect/trap in IDLE or HOLD:
  - fetch_pc<=target, if_valid drops next cycle, go REQ.
  - A simultaneous handoff still counts as consumed, but fetch_pc takes the target, not +4.
- Redirect/trap in REQ or WAIT:
  - pending<=target, kill<=1.
  - The in-flight or still-requested access completes normally; its response is discarded.
  - The request is never retracted; imem_addr stays stable until gnt.
- Redirect/trap in WAIT on the same cycle as rvalid with kill=0: data discarded, fetch_pc<=target, go REQ.
- Redirect/trap while kill=1 already: pending overwritten (latest wins).
- Reset asserted mid-operation: all state returns to reset values immediately. An outstanding imem response after reset release is not expected and is not filtered.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=2'b00 is replaced by target TRAP_VEC.
  - pc_misaligned pulses 1 cycle, the cycle after the redirect.
  - trap_valid in the same cycle still takes priority, with no pulse.
- Undefined: redirect_pc[1:0] forced to 2'b00; pc_misaligned tied 0.

Decomposition:
- fetch_pkg holds:
  - fetch_state_e enum {IDLE, REQ, WAIT, HOLD}.
  - NOP_INSTR = 32'h0000_0013.
  - PC_INC = 32'd4.
- Sub-module pc_reg_en: 32-bit register with async active-low reset to a parameter value and a load enable; used for fetch_pc.

Test Plan:
- Reset release, gnt and rvalid each 1 cycle, if_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; if_pc matches; 3 cycles per instruction.
- if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc and if_instr held constant; no new imem_req.
- redirect_pc=0x200 in WAIT before rvalid -> response dropped (if_valid stays 0), next imem_addr=0x200.
- trap_valid and redirect_valid together in HOLD -> next imem_addr=0x100; if_valid=0 the next cycle.
- fetch_pc=0xFFFF_FFFC handoff -> next imem_addr=0x0.
- MISALIGN_TRAP_EN defined, redirect_pc=0x202 -> pc_misaligned 1-cycle pulse, next imem_addr=0x100; undefined -> next imem_addr=0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_e : fetch FSM states (IDLE, REQ, WAIT, HOLD)
//   NOP_INSTR     : canonical RV32 NOP (addi x0, x0, 0), shown to decode
//                   before the first real fetch
//   PC_INC        : sequential PC step for 32-bit instructions
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage : fetch_pkg

// File: rtl/pc_reg_en.sv
// ----------------------------------------------------------------------------
// pc_reg_en
// 32-bit register with load enable and asynchronous active-low reset to a
// parameterised value. Holds the fetch PC.
//   clk   in  1   clock
//   rst_n in  1   asynchronous active-low reset (q <= RESET_VAL)
//   en    in  1   load enable
//   d     in  32  next value, taken when en=1
//   q     out 32  register contents
// ----------------------------------------------------------------------------
module pc_reg_en #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : pc_reg_en

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Owns the fetch PC of a single-issue RV32 core. Issues one instruction
// memory request at a time (req/gnt, then rvalid) and presents the fetched
// word to decode over a valid/ready handshake. Redirects (branch/jump) and
// traps change the next fetch target; a request already issued is never
// retracted, its response is discarded instead.
//
// Configuration macro: MISALIGN_TRAP_EN
//   defined   : a redirect to a non-word-aligned target fetches TRAP_VEC and
//               pulses pc_misaligned for one cycle (unless trap_valid wins)
//   undefined : redirect_pc[1:0] is forced to 2'b00, pc_misaligned tied 0
//
// Ports:
//   clk            in  1   clock
//   rst_n          in  1   asynchronous active-low reset
//   imem_req       out 1   fetch request
//   imem_addr      out 32  fetch address (the fetch PC register)
//   imem_gnt       in  1   request accepted this cycle
//   imem_rvalid    in  1   read data valid
//   imem_rdata     in  32  instruction word
//   if_valid       out 1   instruction available to decode
//   if_pc          out 32  PC of if_instr
//   if_instr       out 32  instruction to decode
//   if_ready       in  1   decode accepts when if_valid=1
//   redirect_valid in  1   branch/jump taken (1-cycle pulse)
//   redirect_pc    in  32  redirect target
//   trap_valid     in  1   trap/exception (1-cycle pulse)
//   pc_misaligned  out 1   misaligned redirect target pulse
// ----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap_valid,
    output logic        pc_misaligned
);

    fetch_state_e state_q, state_d;

    logic [31:0] fetch_pc;
    logic        pc_load;
    logic [31:0] pc_next;

    logic        kill_q, kill_d;
    logic [31:0] pending_q, pending_d;

    logic        capture;
    logic [31:0] if_pc_q, if_instr_q;

    logic        evt;
    logic [31:0] redirect_target;
    logic [31:0] target;

    // ------------------------------------------------------------------
    // Redirect target qualification
    // ------------------------------------------------------------------
`ifdef MISALIGN_TRAP_EN
    logic misalign_d, misalign_q;

    always_comb begin
        redirect_target = (redirect_pc[1:0] != 2'b00) ? TRAP_VEC : redirect_pc;
        // A simultaneous trap overrides the redirect, so no pulse then.
        misalign_d      = redirect_valid && !trap_valid && (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign pc_misaligned = misalign_q;
`else
    // Low target bits are dropped; keep them visibly consumed.
    logic unused_pc_bits;
    assign unused_pc_bits  = ^redirect_pc[1:0];
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign pc_misaligned   = 1'b0;
`endif

    // Trap outranks redirect when both arrive in the same cycle.
    assign evt    = trap_valid || redirect_valid;
    assign target = trap_valid ? TRAP_VEC : redirect_target;

    // ------------------------------------------------------------------
    // Fetch PC register
    // ------------------------------------------------------------------
    pc_reg_en #(
        .RESET_VAL (RESET_PC)
    ) u_fetch_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_load),
        .d     (pc_next),
        .q     (fetch_pc)
    );

    // ------------------------------------------------------------------
    // FSM state and bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            kill_q    <= 1'b0;
            pending_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_pc_q    <= 32'h0000_0000;
            if_instr_q <= NOP_INSTR;
        end else if (capture) begin
            if_pc_q    <= fetch_pc;
            if_instr_q <= imem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        pc_load   = 1'b0;
        pc_next   = fetch_pc;
        kill_d    = kill_q;
        pending_d = pending_q;
        capture   = 1'b0;
        imem_req  = 1'b0;
        if_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (evt) begin
                    pc_load = 1'b1;
                    pc_next = target;
                end
                state_d = REQ;
            end

            REQ: begin
                imem_req = 1'b1;
                // The request stays up at the old address; only remember
                // where to go once its response has been dropped.
                if (evt) begin
                    pending_d = target;
                    kill_d    = 1'b1;
                end
                if (imem_gnt) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (imem_rvalid) begin
                    if (evt) begin
                        // Fresh target in the response cycle wins over both
                        // the data and any older pending target.
                        pc_load = 1'b1;
                        pc_next = target;
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else if (kill_q) begin
                        pc_load = 1'b1;
                        pc_next = pending_q;
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end else if (evt) begin
                    pending_d = target;
                    kill_d    = 1'b1;
                end
            end

            HOLD: begin
                if_valid = 1'b1;
                // A handoff coinciding with a redirect is consumed, but the
                // PC follows the redirect rather than stepping by 4.
                if (evt) begin
                    pc_load = 1'b1;
                    pc_next = target;
                    state_d = REQ;
                end else if (if_ready) begin
                    pc_load = 1'b1;
                    pc_next = fetch_pc + PC_INC;
                    state_d = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr = fetch_pc;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. An instruction memory model answers
// every granted request with mem_word(addr) after a configurable latency.
// Expected request addresses and expected decode handoffs are queued as
// the stimulus is written and popped as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

`ifdef MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_ADDR  = 32'h0000_0100;
    localparam logic [31:0] MIS_PULSE = 32'd1;
`else
    localparam logic [31:0] MIS_ADDR  = 32'h0000_0200;
    localparam logic [31:0] MIS_PULSE = 32'd0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } handoff_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic        pc_misaligned;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] addr_q[$];
    handoff_t    ho_q[$];
    int          ho_cyc[$];

    // memory model state
    logic        g_fire = 1'b0;
    logic [31:0] g_addr = '0;
    logic        busy   = 1'b0;
    int          cnt    = 0;
    int          lat    = 1;
    logic [31:0] raddr  = '0;

    fetch_sequencer #(
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .pc_misaligned  (pc_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responses and grant for the cycle that just started.
    task automatic drive_model();
        imem_rvalid = 1'b0;
        if (busy) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(raddr);
                busy        = 1'b0;
            end
        end
        if (g_fire) begin
            g_fire = 1'b0;
            if (lat <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(g_addr);
            end else begin
                busy  = 1'b1;
                cnt   = lat - 1;
                raddr = g_addr;
            end
        end
        imem_gnt = imem_req;
    endtask

    // Scoreboard: compare granted addresses and decode handoffs mid-cycle.
    task automatic monitor();
        if (imem_req && imem_gnt) begin
            g_fire = 1'b1;
            g_addr = imem_addr;
            checks++;
            assert (addr_q.size() > 0) else begin
                errors++;
                $error("FAIL req_addr: observed request to %h, expected none", imem_addr);
            end
            if (addr_q.size() > 0) check("req_addr", imem_addr, addr_q.pop_front());
        end
        if (if_valid && if_ready) begin
            checks++;
            assert (ho_q.size() > 0) else begin
                errors++;
                $error("FAIL handoff: observed pc=%h, expected none", if_pc);
            end
            if (ho_q.size() > 0) begin
                handoff_t e;
                e = ho_q.pop_front();
                check("handoff_pc", if_pc, e.pc);
                check("handoff_instr", if_instr, e.instr);
            end
            ho_cyc.push_back(cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive_model();
        cyc++;
    endtask

    task automatic push_ho(input logic [31:0] pc);
        handoff_t h;
        h.pc    = pc;
        h.instr = mem_word(pc);
        ho_q.push_back(h);
    endtask

    task automatic run_until_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (if_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(if_valid), 32'd1);
    endtask

    task automatic run_until_drained(input string tag, input int budget);
        int n;
        n = 0;
        while (ho_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(ho_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_instr;

        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_valid     = 1'b0;

        // ---------------- reset values ----------------
        #12;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, NOP);
        check("rst_pc_misaligned", 32'(pc_misaligned), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_model();

        // ---------------- sequential fetch, 3 cycles each ----------------
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h4);
        addr_q.push_back(32'h8);
        addr_q.push_back(32'hC);
        push_ho(32'h0);
        push_ho(32'h4);
        push_ho(32'h8);
        if_ready = 1'b1;
        run_until_drained("seq_drain", 30);
        if_ready = 1'b0;
        check("seq_count", 32'(ho_cyc.size()), 32'd3);
        if (ho_cyc.size() >= 3) begin
            check("seq_gap0", 32'(ho_cyc[1] - ho_cyc[0]), 32'd3);
            check("seq_gap1", 32'(ho_cyc[2] - ho_cyc[1]), 32'd3);
        end

        // ---------------- decode back-pressure in HOLD ----------------
        run_until_valid("stall_reach_hold", 10);
        held_pc    = if_pc;
        held_instr = if_instr;
        check("stall_pc", held_pc, 32'hC);
        check("stall_instr", held_instr, mem_word(32'hC));
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_pc_hold", if_pc, held_pc);
            check("stall_instr_hold", if_instr, held_instr);
            check("stall_no_req", 32'(imem_req), 32'd0);
            tick();
        end
        push_ho(32'hC);
        addr_q.push_back(32'h10);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;

        // ---------------- redirect in WAIT before rvalid ----------------
        lat = 2;
        tick();                              // 0x10 granted, now WAIT
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        addr_q.push_back(32'h200);
        tick();
        redirect_valid = 1'b0;
        check("wait_redir_valid0", 32'(if_valid), 32'd0);
        tick();                              // stale response dropped
        check("wait_redir_valid1", 32'(if_valid), 32'd0);
        check("wait_redir_addr", imem_addr, 32'h200);
        lat = 1;
        push_ho(32'h200);
        addr_q.push_back(32'h204);
        if_ready = 1'b1;
        run_until_drained("wait_redir_drain", 10);
        if_ready = 1'b0;

        // ---------------- trap + redirect together in HOLD ----------------
        run_until_valid("trap_reach_hold", 10);
        check("trap_hold_pc", if_pc, 32'h204);
        trap_valid     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        addr_q.push_back(TRAP_VEC);
        tick();
        trap_valid     = 1'b0;
        redirect_valid = 1'b0;
        check("trap_valid_drop", 32'(if_valid), 32'd0);
        check("trap_addr", imem_addr, TRAP_VEC);
        run_until_valid("trap_fetch", 10);
        check("trap_fetch_pc", if_pc, TRAP_VEC);
        check("trap_fetch_instr", if_instr, mem_word(TRAP_VEC));

        // ---------------- PC wrap at top of address space ----------------
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        addr_q.push_back(32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        run_until_valid("wrap_reach_hold", 10);
        push_ho(32'hFFFF_FFFC);
        addr_q.push_back(32'h0);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_consumed", 32'(ho_q.size()), 32'd0);

        // ---------------- misaligned redirect ----------------
        run_until_valid("mis_reach_hold", 10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h202;
        addr_q.push_back(MIS_ADDR);
        tick();
        redirect_valid = 1'b0;
        check("mis_pulse", 32'(pc_misaligned), MIS_PULSE);
        check("mis_addr", imem_addr, MIS_ADDR);
        tick();
        check("mis_pulse_end", 32'(pc_misaligned), 32'd0);

        // ---------------- handoff coinciding with redirect ----------------
        run_until_valid("both_reach_hold", 10);
        push_ho(MIS_ADDR);
        addr_q.push_back(32'h400);
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        tick();
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        check("both_consumed", 32'(ho_q.size()), 32'd0);
        check("both_addr", imem_addr, 32'h400);
        check("both_valid", 32'(if_valid), 32'd0);

        // ---------------- redirect on the rvalid cycle ----------------
        tick();                              // 0x400 granted, rvalid now
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        addr_q.push_back(32'h500);
        tick();
        redirect_valid = 1'b0;
        check("rv_redir_valid", 32'(if_valid), 32'd0);
        check("rv_redir_addr", imem_addr, 32'h500);
        tick();                              // 0x500 granted
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("ho_q_drained", 32'(ho_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_sequencer
